key_click_decoder: RTL and testbench

Click-burst decoder that sits directly downstream of the key debouncer. It consumes the debouncer's one-cycle press strobe and groups strobes that arrive within a programmable inter-click window into one burst. When the window expires it reports the burst length (single, double, triple… click) with a valid pulse and an overflow flag. Its output feeds the UI/command logic.

---
 rtl/key_click_decoder.sv | 121 ++++++++++++
 tb/tb_key_click_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_click_decoder.sv
// key_click_decoder: groups debounced press strobes into click bursts.
// Strobes closer together than WINDOW_TICKS cycles belong to one burst; when
// the window expires the burst length and an overflow flag are reported.
// Optional feature: define KEY_CLICK_DECODER_HANDSHAKE_EN to add click_ready_i
// and a HOLD state that keeps the result valid until the consumer accepts it.
module key_click_decoder #(
    parameter int  CLK_FREQ_MHZ = 5,
    parameter int  WINDOW_US    = 100,
    parameter int  MAX_CLICKS   = 4,
    localparam int CW           = $clog2(MAX_CLICKS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          key_pressed_stb_i,
`ifdef KEY_CLICK_DECODER_HANDSHAKE_EN
    input  logic          click_ready_i,
`endif
    output logic          click_valid_o,
    output logic [CW-1:0] click_cnt_o,
    output logic          click_ovf_o,
    output logic          busy_o
);

    localparam int WINDOW_TICKS = WINDOW_US * CLK_FREQ_MHZ;
    localparam int TW           = $clog2(WINDOW_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
`ifdef KEY_CLICK_DECODER_HANDSHAKE_EN
        HOLD,
`endif
        COLLECT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_out_d;
    logic            ovf_out_d;
    logic            valid_d;

    // State, burst counters and the registered result; reset drops any partial burst.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            click_valid_o <= 1'b0;
            click_cnt_o   <= '0;
            click_ovf_o   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            click_valid_o <= valid_d;
            click_cnt_o   <= cnt_out_d;
            click_ovf_o   <= ovf_out_d;
        end
    end

    // Next-state logic: a strobe always restarts the window, even on the expiry cycle.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        cnt_out_d = click_cnt_o;
        ovf_out_d = click_ovf_o;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_pressed_stb_i) begin
                    state_d = COLLECT;
                    count_d = CW'(1);
                    timer_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            COLLECT: begin
                if (key_pressed_stb_i) begin
                    timer_d = '0;
                    if (count_q < CW'(MAX_CLICKS)) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (timer_q == TW'(WINDOW_TICKS - 1)) begin
                    cnt_out_d = count_q;
                    ovf_out_d = ovf_q;
                    valid_d   = 1'b1;
                    timer_d   = '0;
`ifdef KEY_CLICK_DECODER_HANDSHAKE_EN
                    state_d   = HOLD;
`else
                    state_d   = IDLE;
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef KEY_CLICK_DECODER_HANDSHAKE_EN
            HOLD: begin
                if (click_ready_i) begin
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == COLLECT);

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed self-checking bench for key_click_decoder (WINDOW_TICKS = 10, MAX_CLICKS = 4).
// Edge numbers in the stimulus masks count rising clock edges from the start
// of each applyStimulus call, starting at edge 0.
module tb_key_click_decoder;

    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          stb;
    logic          click_valid;
    logic [CW-1:0] click_cnt;
    logic          click_ovf;
    logic          busy;
`ifdef KEY_CLICK_DECODER_HANDSHAKE_EN
    logic          click_ready;
`endif

    int total_checks;
    int bad_checks;

    // Results gathered by applyStimulus for the most recent stimulus window.
    int n_valid;
    int n_rise;
    int first_edge;
    int last_edge;
    int cnt_first;
    int cnt_last;
    int ovf_last;
    int busy_at0;
    int busy_at_first;
    int cnt_changed;

    key_click_decoder #(
        .CLK_FREQ_MHZ (5),
        .WINDOW_US    (2),
        .MAX_CLICKS   (4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .key_pressed_stb_i (stb),
`ifdef KEY_CLICK_DECODER_HANDSHAKE_EN
        .click_ready_i     (click_ready),
`endif
        .click_valid_o     (click_valid),
        .click_cnt_o       (click_cnt),
        .click_ovf_o       (click_ovf),
        .busy_o            (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives strobe/ready per edge for n_edges edges and records what valid did.
    task automatic applyStimulus(input logic [63:0] stb_mask, input logic [63:0] rdy_mask,
                                 input int n_edges);
        logic prev_valid;
        n_valid       = 0;
        n_rise        = 0;
        first_edge    = -1;
        last_edge     = -1;
        cnt_first     = -1;
        cnt_last      = -1;
        ovf_last      = -1;
        busy_at0      = -1;
        busy_at_first = -1;
        cnt_changed   = 0;
        prev_valid    = 1'b0;
        for (int e = 0; e < n_edges; e++) begin
            stb = stb_mask[e];
`ifdef KEY_CLICK_DECODER_HANDSHAKE_EN
            click_ready = rdy_mask[e];
`else
            if (rdy_mask[e] === 1'bx) begin
                $display("[TB] ready mask bit undefined at edge %0d", e);
            end
`endif
            @(posedge clk);
            #1;
            if (e == 0) busy_at0 = int'(busy);
            if (click_valid) begin
                n_valid++;
                if (!prev_valid) n_rise++;
                if (first_edge < 0) begin
                    first_edge    = e;
                    cnt_first     = int'(click_cnt);
                    busy_at_first = int'(busy);
                end else if (prev_valid && (int'(click_cnt) != cnt_last)) begin
                    cnt_changed = 1;
                end
                last_edge = e;
                cnt_last  = int'(click_cnt);
                ovf_last  = int'(click_ovf);
            end
            prev_valid = click_valid;
        end
        stb = 1'b0;
    endtask

    localparam logic [63:0] ALL_READY = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        rst = 1'b1;
        stb = 1'b1;
`ifdef KEY_CLICK_DECODER_HANDSHAKE_EN
        click_ready = 1'b1;
`endif

        // Reset held for 3 cycles with strobes present: everything stays 0.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_outputs", int'({click_valid, click_cnt, click_ovf, busy}), 0);
        end
        rst = 1'b0;
        stb = 1'b0;
        applyStimulus(64'h0, ALL_READY, 12);
        checkOutput("reset_no_valid_after", n_valid, 0);
        checkOutput("reset_not_busy", int'(busy), 0);

        // Single click at edge 0: valid pulse after edge 10.
        $display("[TB] single click");
        applyStimulus(64'h1, ALL_READY, 14);
        checkOutput("single_busy_edge0", busy_at0, 1);
        checkOutput("single_valid_edge", first_edge, 10);
        checkOutput("single_valid_cycles", n_valid, 1);
        checkOutput("single_cnt", cnt_first, 1);
        checkOutput("single_ovf", ovf_last, 0);
        checkOutput("single_busy_falls", busy_at_first, 0);

        // Strobe at edge 9 still extends the burst started at edge 0.
        $display("[TB] double click at window boundary");
        applyStimulus(64'h201, ALL_READY, 23);
        checkOutput("double_valid_edge", first_edge, 19);
        checkOutput("double_results", n_rise, 1);
        checkOutput("double_cnt", cnt_first, 2);
        checkOutput("double_ovf", ovf_last, 0);

`ifndef KEY_CLICK_DECODER_HANDSHAKE_EN
        // Strobe on the edge after expiry (valid visible, FSM idle) starts a new burst.
        $display("[TB] back-to-back bursts");
        applyStimulus(64'h801, ALL_READY, 25);
        checkOutput("b2b_results", n_rise, 2);
        checkOutput("b2b_first_edge", first_edge, 10);
        checkOutput("b2b_second_edge", last_edge, 21);
        checkOutput("b2b_cnt_first", cnt_first, 1);
        checkOutput("b2b_cnt_second", cnt_last, 1);
`endif

        // Six strobes three apart saturate at 4 with overflow; last strobe at edge 15.
        $display("[TB] saturation");
        applyStimulus(64'h9249, ALL_READY, 30);
        checkOutput("sat_results", n_rise, 1);
        checkOutput("sat_valid_edge", first_edge, 25);
        checkOutput("sat_cnt", cnt_first, 4);
        checkOutput("sat_ovf", ovf_last, 1);
        checkOutput("sat_cnt_held", int'(click_cnt), 4);
        checkOutput("sat_ovf_held", int'(click_ovf), 1);

        // Reset mid-burst: strobes at edges 0 and 4, reset pulse around edge 6.
        $display("[TB] reset mid-burst");
        applyStimulus(64'h11, ALL_READY, 6);
        checkOutput("midrst_busy_before", int'(busy), 1);
        rst = 1'b1;
        #2;
        checkOutput("midrst_async_busy", int'(busy), 0);
        checkOutput("midrst_async_cnt", int'(click_cnt), 0);
        checkOutput("midrst_async_ovf", int'(click_ovf), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(64'h0, ALL_READY, 20);
        checkOutput("midrst_no_valid", n_valid, 0);
        applyStimulus(64'h1, ALL_READY, 14);
        checkOutput("midrst_next_edge", first_edge, 10);
        checkOutput("midrst_next_cnt", cnt_first, 1);
        checkOutput("midrst_next_ovf", ovf_last, 0);

`ifdef KEY_CLICK_DECODER_HANDSHAKE_EN
        // Two clicks (edges 0, 2) -> valid from edge 12; ready low until edge 18.
        // Strobes at 14 (during HOLD) and 18 (accept edge) must be ignored.
        $display("[TB] handshake hold");
        applyStimulus(64'h44005, 64'hFFFF_FFFF_FFFC_0000, 40);
        checkOutput("hs_valid_edge", first_edge, 12);
        checkOutput("hs_valid_cycles", n_valid, 6);
        checkOutput("hs_last_edge", last_edge, 17);
        checkOutput("hs_results", n_rise, 1);
        checkOutput("hs_cnt", cnt_first, 2);
        checkOutput("hs_cnt_stable", cnt_changed, 0);
        checkOutput("hs_busy_in_hold", busy_at_first, 0);
        checkOutput("hs_idle_after", int'(busy), 0);
`endif

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
